load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block consuming the ALU result as effective address and rs2 as store data; issues one aligned word access per load/store over a req/ready + rvalid data-memory handshake.
- Performs byte/half lane steering and load sign/zero extension.
- Stalls the pipeline until each access completes.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory instruction present in this stage.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign field.
- req_addr  in  ADDR_WIDTH  effective address (ALU output).
- req_wdata  in  DATA_WIDTH  store data (rs2).
- stall  out  1  hold upstream stages.
- done  out  1  one-cycle completion pulse.
- fault  out  1  misaligned/illegal access; qualified by done.
- load_data  out  DATA_WIDTH  extended load result; qualified by done.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-shifted store data.
- mem_ready  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_WIDTH  read word.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, fault, load_data, stall.
  - Capture registers cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On req_valid, decode req_funct3 and req_addr[1:0], and capture addr, wdata, funct3, store.
  - Legal access -> REQ. Illegal or misaligned access -> DONE with fault=1.
- REQ:
  - mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata driven from the captured registers.
  - Outputs are held stable until mem_ready=1.
  - On mem_ready: store -> DONE; load -> WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture extended mem_rdata into load_data -> DONE.
  - mem_rvalid is ignored outside WAIT.
- DONE:
  - done=1 for exactly one cycle; load_data/fault valid; always -> IDLE.
  - load_data and fault hold until the next access completes.
- stall = (IDLE & req_valid) | REQ | WAIT, combinational. stall=0 in DONE, so the pipeline advances.
- req_* are sampled only in IDLE; changes while stalled are ignored.
- Latency with zero wait states:
  - Store: 3 cycles accept->done.
  - Load: 4 cycles accept->done.
  - Fault: 2 cycles accept->done.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and raises fault.
- Misaligned access raises fault:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- Faulted access behaviour: no mem_req, load_data=0.
- Byte enables:
  - Byte access: mem_be = 0001<<addr[1:0].
  - Half access: mem_be = 0011<<addr[1:0].
  - Word access: mem_be = 1111.
- mem_wdata is the store data replicated into the target lane(s): byte in all four lanes, half in both halves.
- Loads: select the lane by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU) to 32 bits.
- Back-to-back accesses: a new req_valid in the cycle after DONE (IDLE) is accepted normally; no bubble is required beyond DONE.
- Reset asserted mid-REQ/WAIT:
  - mem_req drops asynchronously.
  - Any later mem_rvalid for the aborted access is discarded, because the state is no longer WAIT.

Decomposition:
- lsu_pkg holds:
  - state enum (IDLE, REQ, WAIT, DONE);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the size-decode function.
- Sub-module lsu_align, purely combinational, does byte-enable generation, store lane replication, and load lane select/extension. load_store_unit holds the FSM and capture registers.

Test Plan:
- SW addr=0x1000, wdata=0xDEADBEEF, mem_ready immediate -> mem_addr=0x1000, mem_be=1111, mem_we=1, done on cycle 3, fault=0.
- LB addr=0x2003, mem_rdata=0x80AABBCC -> mem_be=1000, load_data=0xFFFFFF80.
- LHU addr=0x2002, mem_rdata=0x80AABBCC -> load_data=0x000080AA.
- LB addr=0x2003, same rdata -> load_data=0xFFFFFF80 (sign-extension check).
- LW addr=0x3002 -> no mem_req, done after 2 cycles, fault=1, load_data=0.
- LW with mem_ready delayed 3 cycles and mem_rvalid delayed 2 more -> mem_req and mem_addr stable throughout, stall=1 until DONE, done pulses exactly once.
- rst_n=0 while in WAIT, then mem_rvalid=1 after release -> state IDLE, done stays 0, load_data=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the FSM state encoding, the RV32I load/store funct3 codes, the
// access-size decode and the alignment check used by both the FSM and the
// lane-steering logic.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    // Access size for a funct3 code; the unsigned variants only exist for loads.
    function automatic size_e decode_size(input logic [2:0] funct3, input logic store);
        size_e sz;
        case (funct3)
            F3_B:    sz = SZ_BYTE;
            F3_H:    sz = SZ_HALF;
            F3_W:    sz = SZ_WORD;
            F3_BU:   sz = store ? SZ_ILLEGAL : SZ_BYTE;
            F3_HU:   sz = store ? SZ_ILLEGAL : SZ_HALF;
            default: sz = SZ_ILLEGAL;
        endcase
        return sz;
    endfunction

    // Natural alignment check: halves on even addresses, words on multiples of 4.
    function automatic logic misaligned(input size_e sz, input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   funct3    - access size/sign code
//   addr_lo   - byte offset within the word
//   wdata     - raw store data (rs2)
//   rdata     - raw read word from memory
//   be        - byte enables for the access
//   wdata_rep - store data replicated into every lane of its size
//   rdata_ext - selected load lane, sign/zero extended to 32 bits
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    size_e       size_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte enables and store replication from the access size.
    always_comb begin
        size_s    = decode_size(funct3, 1'b0);
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        case (size_s)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0000_0000;
            end
        endcase
    end

    // Load lane selection followed by sign or zero extension.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        rdata_ext = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
            F3_W:    rdata_ext = rdata;
            F3_BU:   rdata_ext = {24'h000000, byte_s};
            F3_HU:   rdata_ext = {16'h0000, half_s};
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one aligned word access per instruction
// over a req/ready + rvalid memory handshake, stalling upstream until done.
// Ports:
//   clk, rst_n                - clock and async active-low reset
//   req_valid/store/funct3    - memory instruction in this stage
//   req_addr, req_wdata       - effective address and store data
//   stall                     - hold upstream stages
//   done, fault, load_data    - completion pulse, error flag, load result
//   mem_req/we/addr/be/wdata  - memory request (registered)
//   mem_ready, mem_rvalid,
//   mem_rdata                 - memory accept and read-data return
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  done,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                  state_r;
    logic [2:0]              f3_r;
    logic [1:0]              addr_lo_r;
    logic                    store_r;
    logic                    done_r;
    logic                    fault_r;
    logic [DATA_WIDTH-1:0]   load_data_r;
    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [3:0]              mem_be_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;

    size_e                   req_size_s;
    logic                    illegal_s;
    logic [2:0]              align_f3_s;
    logic [1:0]              align_lo_s;
    logic [3:0]              be_s;
    logic [DATA_WIDTH-1:0]   wdata_rep_s;
    logic [DATA_WIDTH-1:0]   rdata_ext_s;

    // Legality of the instruction presented in IDLE.
    always_comb begin
        req_size_s = decode_size(req_funct3, req_store);
        illegal_s  = (req_size_s == SZ_ILLEGAL) || misaligned(req_size_s, req_addr[1:0]);
    end

    // The steering logic sees the live request while accepting and the
    // captured request afterwards, so one instance serves both store setup
    // and load extension.
    always_comb begin
        align_f3_s = f3_r;
        align_lo_s = addr_lo_r;
        if (state_r == IDLE) begin
            align_f3_s = req_funct3;
            align_lo_s = req_addr[1:0];
        end else begin
            align_f3_s = f3_r;
            align_lo_s = addr_lo_r;
        end
    end

    lsu_align u_align (
        .funct3    (align_f3_s),
        .addr_lo   (align_lo_s),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (be_s),
        .wdata_rep (wdata_rep_s),
        .rdata_ext (rdata_ext_s)
    );

    // Access FSM with capture registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            f3_r        <= 3'b000;
            addr_lo_r   <= 2'b00;
            store_r     <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
            load_data_r <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (req_valid) begin
                        f3_r      <= req_funct3;
                        addr_lo_r <= req_addr[1:0];
                        store_r   <= req_store;
                        if (illegal_s) begin
                            // Faulted accesses never reach memory.
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            fault_r     <= 1'b1;
                            load_data_r <= '0;
                        end else begin
                            state_r     <= REQ;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_store;
                            mem_addr_r  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_r    <= be_s;
                            mem_wdata_r <= wdata_rep_s;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (store_r) begin
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            fault_r     <= 1'b0;
                            load_data_r <= '0;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_r     <= DONE;
                        done_r      <= 1'b1;
                        fault_r     <= 1'b0;
                        load_data_r <= rdata_ext_s;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    done_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the accept cycle so the instruction stays put until DONE.
    always_comb begin
        stall = ((state_r == IDLE) && req_valid) || (state_r == REQ) || (state_r == WAIT);
    end

    assign done      = done_r;
    assign fault     = fault_r;
    assign load_data = load_data_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// random accesses against a byte-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int passed = 0;
    int total  = 0;

    logic [7:0] mem_model [int unsigned];

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    // One complete access: drives the request, plays the memory side with the
    // given wait states and checks every cycle against the model.
    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int rdly, input int vdly);
        int          n;
        int          k;
        logic        legal;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] wa;
        logic [31:0] mask;

        // Size in bytes from the low funct3 bits; bit 2 means "unsigned load".
        case (f3[1:0])
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        if (n == 0) legal = 1'b0;
        else if (f3[2] && (st || n == 4)) legal = 1'b0;
        else legal = ((addr % n) == 0);

        exp_be = ((32'd1 << n) - 32'd1) << addr[1:0];
        exp_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        wa     = addr & 32'hFFFF_FFFC;
        word   = {model_rd(wa + 32'd3), model_rd(wa + 32'd2), model_rd(wa + 32'd1), model_rd(wa)};
        v      = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(model_rd(addr + i)) << (8 * i));
        if (n > 0 && n < 4 && !f3[2] && v[8 * n - 1]) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            v    = v | ~mask;
        end

        @(negedge clk);
        check_eq("done_single_pulse", {31'd0, done}, 32'd0);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        check_eq("stall_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        k = 1;
        // Garbage on the request bus while busy must be ignored.
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_store  = 1'($urandom);

        if (!legal) begin
            check_eq("fault_no_req", {31'd0, mem_req}, 32'd0);
            check_eq("fault_done", {31'd0, done}, 32'd1);
            check_eq("fault_flag", {31'd0, fault}, 32'd1);
            check_eq("fault_load_data", load_data, 32'd0);
            check_eq("fault_stall", {31'd0, stall}, 32'd0);
        end else begin
            for (int c = 0; c <= rdly; c++) begin
                check_eq("req_mem_req", {31'd0, mem_req}, 32'd1);
                check_eq("req_mem_we", {31'd0, mem_we}, {31'd0, st});
                check_eq("req_mem_addr", mem_addr, wa);
                check_eq("req_mem_be", {28'd0, mem_be}, exp_be);
                if (st) check_eq("req_mem_wdata", mem_wdata, exp_wd);
                check_eq("req_stall", {31'd0, stall}, 32'd1);
                check_eq("req_no_done", {31'd0, done}, 32'd0);
                mem_ready  = (c == rdly);
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
                @(negedge clk);
                k++;
                mem_ready  = 1'b0;
                mem_rvalid = 1'b0;
            end
            if (!st) begin
                for (int c = 0; c <= vdly; c++) begin
                    check_eq("wait_mem_req", {31'd0, mem_req}, 32'd0);
                    check_eq("wait_stall", {31'd0, stall}, 32'd1);
                    check_eq("wait_no_done", {31'd0, done}, 32'd0);
                    mem_rvalid = (c == vdly);
                    mem_rdata  = (c == vdly) ? word : 32'hFFFF_FFFF;
                    @(negedge clk);
                    k++;
                    mem_rvalid = 1'b0;
                end
            end
            check_eq("done_pulse", {31'd0, done}, 32'd1);
            check_eq("done_fault", {31'd0, fault}, 32'd0);
            check_eq("done_stall", {31'd0, stall}, 32'd0);
            if (!st) check_eq("load_data", load_data, v);
            check_eq("latency", k, st ? (2 + rdly) : (3 + rdly + vdly));
            if (st) begin
                for (int i = 0; i < n; i++) mem_model[addr + i] = wd[8 * i +: 8];
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #12;
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_load_data", load_data, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during REQ and during WAIT; a late rvalid must be discarded.
        for (int phase = 0; phase < 2; phase++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_store  = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 32'h0000_5000;
            @(negedge clk);
            req_valid = 1'b0;
            if (phase == 1) begin
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                check_eq("wait_before_rst", {31'd0, stall}, 32'd1);
            end else begin
                check_eq("req_before_rst", {31'd0, mem_req}, 32'd1);
            end
            rst_n = 1'b0;
            #1;
            check_eq("abort_mem_req", {31'd0, mem_req}, 32'd0);
            check_eq("abort_stall", {31'd0, stall}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hFFFF_FFFF;
            @(negedge clk);
            mem_rvalid = 1'b0;
            check_eq("abort_done", {31'd0, done}, 32'd0);
            check_eq("abort_load_data", load_data, 32'd0);
            check_eq("abort_stall_idle", {31'd0, stall}, 32'd0);
            @(negedge clk);
            check_eq("abort_done_late", {31'd0, done}, 32'd0);
        end

        mem_model[32'h2000] = 8'hCC;
        mem_model[32'h2001] = 8'hBB;
        mem_model[32'h2002] = 8'hAA;
        mem_model[32'h2003] = 8'h80;

        run_access(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0); // SW
        run_access(1'b0, 3'b000, 32'h0000_2003, 32'h0, 0, 0);          // LB
        run_access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0);          // LHU
        run_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 0);          // LH
        run_access(1'b0, 3'b000, 32'h0000_2003, 32'h0, 0, 0);          // LB again
        run_access(1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 0);          // LW misaligned
        run_access(1'b0, 3'b010, 32'h0000_1000, 32'h0, 3, 2);          // LW slow memory
        run_access(1'b1, 3'b000, 32'h0000_1001, 32'h0000_0055, 1, 0);  // SB lane 1
        run_access(1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234, 0, 0);  // SH upper half
        run_access(1'b0, 3'b010, 32'h0000_1000, 32'h0, 0, 0);          // LW readback
        run_access(1'b1, 3'b100, 32'h0000_1000, 32'h0, 0, 0);          // SBU illegal
        run_access(1'b0, 3'b011, 32'h0000_1000, 32'h0, 0, 0);          // illegal funct3
        run_access(1'b1, 3'b001, 32'h0000_1001, 32'h0, 0, 0);          // SH misaligned

        for (int i = 0; i < 80; i++) begin
            run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       32'h0000_4000 + $urandom_range(0, 31), $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        check_eq("final_done_low", {31'd0, done}, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
